i2c_controller: RTL

Register-access I2C controller: the initiating end of the bus protocol served by the core's I2C peripheral interface. One request performs a complete single-byte register write (S, dev+W, reg, data, P) or register read (S, dev+W, reg, Sr, dev+R, data, NACK, P). It sits behind an APB register block or test sequencer and drives open-drain SCL/SDA pad enables. Timing is derived from a programmable quarter-bit divider.

---
 rtl/i2c_pkg.sv | 41 ++++
 rtl/i2c_ctrl_qtick.sv | 52 +++++
 rtl/i2c_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_pkg : state encoding and bus constants for i2c_controller      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package i2c_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 4'd0,
        ST_START      = 4'd1,
        ST_DEVW       = 4'd2,
        ST_DEVW_ACK   = 4'd3,
        ST_REG        = 4'd4,
        ST_REG_ACK    = 4'd5,
        ST_WDATA      = 4'd6,
        ST_WDATA_ACK  = 4'd7,
        ST_RSTART     = 4'd8,
        ST_DEVR       = 4'd9,
        ST_DEVR_ACK   = 4'd10,
        ST_RDATA      = 4'd11,
        ST_RDATA_NACK = 4'd12,
        ST_STOP       = 4'd13
    } state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    function automatic logic is_ack_state(input state_e s);
        return (s == ST_DEVW_ACK) || (s == ST_REG_ACK) ||
               (s == ST_WDATA_ACK) || (s == ST_DEVR_ACK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_ctrl_qtick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_ctrl_qtick : quarter-bit divider with 2-bit phase and hold     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module i2c_ctrl_qtick
    import i2c_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             run_i,
    input  logic             hold_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic [1:0]       phase_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;

    assign tick_o  = run_i && !hold_i && (cnt_q == div_i);
    assign phase_o = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear_i) begin
            cnt_d   = '0;
            phase_d = Q0;
        end else if (tick_o) begin
            cnt_d   = '0;
            phase_d = phase_q + 2'd1;
        end else if (run_i && !hold_i) begin
            cnt_d   = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= Q0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_controller : single-byte register read/write I2C master        |
// | Optional I2C_CTRL_CLK_STRETCH_EN: honour target SCL stretching.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module i2c_controller
    import i2c_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             rd_wrn_i,
    input  logic [6:0]       dev_addr_i,
    input  logic [7:0]       reg_addr_i,
    input  logic [7:0]       wdata_i,
    input  logic [DIV_W-1:0] clk_div_i,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             scl_o,
    output logic             sda_o,
    output logic [7:0]       rdata_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             nack_o
);

    state_e           state_q, state_d;
    logic [2:0]       bit_q, bit_d;
    logic             rd_q, rd_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             nack_q, nack_d;
    logic             smp_q, smp_d;
    logic             done_q, done_d;
    logic             scl_q, scl_d;
    logic             sda_q, sda_d;

    logic             w_accept;
    logic             w_tick;
    logic             w_hold;
    logic [1:0]       w_phase;
    logic [7:0]       w_tx_byte;
    logic             w_tx_bit;
    logic             w_last_bit;

    assign w_accept   = start_i && (state_q == ST_IDLE);
    assign w_last_bit = (bit_q == 3'd7);

`ifdef I2C_CTRL_CLK_STRETCH_EN
    // While SCL is released the counter only runs once the pad is seen high
    assign w_hold = w_phase[1] && !scl_i;
`else
    logic w_unused_scl;
    assign w_unused_scl = scl_i;
    assign w_hold       = 1'b0;
`endif

    i2c_ctrl_qtick #(
        .DIV_W (DIV_W)
    ) u_qtick (
        .clk     (clk),
        .rst     (rst),
        .clear_i (w_accept),
        .run_i   (state_q != ST_IDLE),
        .hold_i  (w_hold),
        .div_i   (div_q),
        .tick_o  (w_tick),
        .phase_o (w_phase)
    );

    always_comb begin
        w_tx_byte = 8'hFF;
        case (state_q)
            ST_DEVW:  w_tx_byte = {dev_q, RW_WRITE};
            ST_REG:   w_tx_byte = reg_q;
            ST_WDATA: w_tx_byte = wdata_q;
            ST_DEVR:  w_tx_byte = {dev_q, RW_READ};
            default:  w_tx_byte = 8'hFF;
        endcase
        w_tx_bit = w_tx_byte[3'd7 - bit_q];
    end

    // Line levels for the current quarter; registered so pads never glitch
    always_comb begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        case (state_q)
            ST_IDLE:   ;
            ST_START:  sda_d = !w_phase[1];
            ST_RSTART: begin
                scl_d = w_phase[1];
                sda_d = (w_phase != Q3);
            end
            ST_STOP:   begin
                scl_d = w_phase[1];
                sda_d = (w_phase == Q3);
            end
            ST_DEVW, ST_REG, ST_WDATA, ST_DEVR: begin
                scl_d = w_phase[1];
                sda_d = w_tx_bit;
            end
            default:   scl_d = w_phase[1];
        endcase
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        rd_d    = rd_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        div_d   = div_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        nack_d  = nack_q;
        smp_d   = smp_q;
        done_d  = 1'b0;
        if (w_accept) begin
            state_d = ST_START;
            bit_d   = 3'd0;
            rd_d    = rd_wrn_i;
            dev_d   = dev_addr_i;
            reg_d   = reg_addr_i;
            wdata_d = wdata_i;
            div_d   = clk_div_i;
            nack_d  = 1'b0;
        end else if (w_tick) begin
            if (w_phase == Q2) begin
                smp_d = sda_i;
                if (state_q == ST_RDATA) begin
                    rx_d = {rx_q[6:0], sda_i};
                end
            end
            if (w_phase == Q3) begin
                if (is_ack_state(state_q) && smp_q) begin
                    nack_d = 1'b1;
                end
                case (state_q)
                    ST_START:      state_d = ST_DEVW;
                    ST_DEVW:       if (w_last_bit) state_d = ST_DEVW_ACK;
                    ST_DEVW_ACK:   state_d = smp_q ? ST_STOP : ST_REG;
                    ST_REG:        if (w_last_bit) state_d = ST_REG_ACK;
                    ST_REG_ACK:    state_d = smp_q ? ST_STOP :
                                             (rd_q == RW_READ) ? ST_RSTART : ST_WDATA;
                    ST_WDATA:      if (w_last_bit) state_d = ST_WDATA_ACK;
                    ST_WDATA_ACK:  state_d = ST_STOP;
                    ST_RSTART:     state_d = ST_DEVR;
                    ST_DEVR:       if (w_last_bit) state_d = ST_DEVR_ACK;
                    ST_DEVR_ACK:   state_d = smp_q ? ST_STOP : ST_RDATA;
                    ST_RDATA:      if (w_last_bit) begin
                                       rdata_d = rx_q;
                                       state_d = ST_RDATA_NACK;
                                   end
                    ST_RDATA_NACK: state_d = ST_STOP;
                    ST_STOP:       begin
                                       state_d = ST_IDLE;
                                       done_d  = 1'b1;
                                   end
                    default:       state_d = ST_IDLE;
                endcase
                // 3-bit counter wraps back to 0 as each byte completes
                if ((state_q == ST_DEVW) || (state_q == ST_REG) || (state_q == ST_WDATA) ||
                    (state_q == ST_DEVR) || (state_q == ST_RDATA)) begin
                    bit_d = bit_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bit_q   <= 3'd0;
            rd_q    <= RW_WRITE;
            dev_q   <= 7'd0;
            reg_q   <= 8'd0;
            wdata_q <= 8'd0;
            div_q   <= '0;
            rx_q    <= 8'd0;
            rdata_q <= 8'd0;
            nack_q  <= 1'b0;
            smp_q   <= 1'b1;
            done_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            rd_q    <= rd_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            div_q   <= div_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            nack_q  <= nack_d;
            smp_q   <= smp_d;
            done_q  <= done_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
        end
    end

    assign scl_o   = scl_q;
    assign sda_o   = sda_q;
    assign rdata_o = rdata_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = done_q;
    assign nack_o  = nack_q;

endmodule
`default_nettype wire
